// File: rtl/cpu_pkg.sv
// Instruction-field positions and opcode/funct constants shared by the front end.
package cpu_pkg;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int FN_MSB = 5;
  localparam int FN_LSB = 0;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1c;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_MADD  = 6'h00;
endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle; the queue takes the slave side.
interface if_id_queue_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH) + 1
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_pc;
  logic [DATA_W-1:0] in_ir;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_pc;
  logic [DATA_W-1:0] out_ir;
  logic              out_md;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_pc, in_ir, out_ready,
    input  in_ready, out_valid, out_pc, out_ir, out_md, count
  );

  modport slave (
    input  in_valid, in_pc, in_ir, out_ready,
    output in_ready, out_valid, out_pc, out_ir, out_md, count
  );
endinterface

// File: rtl/md_predecode.sv
// Combinational flag: instruction reads or writes the HI/LO multiply/divide unit.
module md_predecode
  import cpu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic       md
);
  always_comb begin
    md = 1'b0;
    if (op == OP_SPECIAL) begin
      case (funct)
        FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: md = 1'b1;
        default:                            md = 1'b0;
      endcase
    end else if (op == OP_SPECIAL2 && funct == FN_MADD) begin
      md = 1'b1;
    end
  end
endmodule

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: circular buffer, 1-cycle push-to-visible, full accepts push while popping.
// Optional per-entry HI/LO predecode flag under IF_ID_MD_PREDECODE_EN.
module if_id_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input logic          clk,
  input logic          reset,
  input logic          flush,
  if_id_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] pc_mem [DEPTH];
  logic [DATA_W-1:0] ir_mem [DEPTH];
  logic              full;
  logic              out_vld;
  logic              push;
  logic              pop;

  assign full       = (cnt == CNT_W'(DEPTH));
  assign out_vld    = (cnt != '0);
  assign q.in_ready = !full || q.out_ready;
  assign q.out_valid = out_vld;
  assign q.count    = cnt;
  assign push       = q.in_valid && q.in_ready;
  assign pop        = out_vld && q.out_ready;

  // Bubble outputs are zero so an empty head decodes as a NOP.
  assign q.out_pc = out_vld ? pc_mem[rd_ptr] : '0;
  assign q.out_ir = out_vld ? ir_mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i] <= '0;
        ir_mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr] <= q.in_pc;
        ir_mem[wr_ptr] <= q.in_ir;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        cnt <= cnt + CNT_W'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

`ifdef IF_ID_MD_PREDECODE_EN
  import cpu_pkg::*;

  logic in_md;
  logic md_mem [DEPTH];

  md_predecode u_md_predecode (
    .op    (q.in_ir[OP_MSB:OP_LSB]),
    .funct (q.in_ir[FN_MSB:FN_LSB]),
    .md    (in_md)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        md_mem[i] <= 1'b0;
      end
    end else if (!flush && push) begin
      md_mem[wr_ptr] <= in_md;
    end
  end

  assign q.out_md = out_vld && md_mem[rd_ptr];
`else
  assign q.out_md = 1'b0;
`endif
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue at DATA_W=32, DEPTH=2.
module tb_if_id_queue;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
`ifdef IF_ID_MD_PREDECODE_EN
  localparam bit MD_ON = 1'b1;
`else
  localparam bit MD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   tests = 0;
  int   fails = 0;

  if_id_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) qi ();

  if_id_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .q     (qi)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0;
    qi.in_valid = 1'b0; qi.out_ready = 1'b0; qi.in_pc = '0; qi.in_ir = '0;
    tick(); tick();
    tests++; if (qi.count !== 2'd0) begin fails++; $display("FAIL rst_count: got %0d want 0", qi.count); end
    tests++; if (qi.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", qi.out_valid); end
    tests++; if (qi.out_ir !== 32'h0 || qi.out_pc !== 32'h0 || qi.out_md !== 1'b0) begin
      fails++; $display("FAIL rst_out_data: got pc=%h ir=%h md=%b want zeros", qi.out_pc, qi.out_ir, qi.out_md); end
    reset = 1'b1;
    tick();
    tests++; if (qi.in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b want 1", qi.in_ready); end
  endtask

  task automatic test_fill();
    qi.out_ready = 1'b0;
    qi.in_valid = 1'b1; qi.in_pc = 32'h3000; qi.in_ir = 32'h00851020;
    tick();
    qi.in_pc = 32'h3004; qi.in_ir = 32'h00430018;
    tick();
    qi.in_valid = 1'b0;
    #1;
    tests++; if (qi.count !== 2'd2) begin fails++; $display("FAIL fill_count: got %0d want 2", qi.count); end
    tests++; if (qi.in_ready !== 1'b0) begin fails++; $display("FAIL fill_in_ready: got %b want 0", qi.in_ready); end
    tests++; if (qi.out_pc !== 32'h3000) begin fails++; $display("FAIL fill_out_pc: got %h want 3000", qi.out_pc); end
    tests++; if (qi.out_md !== 1'b0) begin fails++; $display("FAIL fill_out_md: got %b want 0", qi.out_md); end
    qi.out_ready = 1'b1;
    #1;
    tests++; if (qi.in_ready !== 1'b1) begin fails++; $display("FAIL full_ready_comb: got %b want 1", qi.in_ready); end
  endtask

  // Queue is full (3000, 3004): push 3008 while popping 3000.
  task automatic test_back_to_back();
    qi.in_valid = 1'b1; qi.in_pc = 32'h3008; qi.in_ir = 32'h00001012;
    qi.out_ready = 1'b1;
    tick();
    qi.in_valid = 1'b0;
    tests++; if (qi.count !== 2'd2) begin fails++; $display("FAIL b2b_count: got %0d want 2", qi.count); end
    tests++; if (qi.out_pc !== 32'h3004) begin fails++; $display("FAIL b2b_head0: got %h want 3004", qi.out_pc); end
    tests++; if (qi.out_md !== MD_ON) begin fails++; $display("FAIL b2b_md_mult: got %b want %b", qi.out_md, MD_ON); end
    tick();
    tests++; if (qi.out_pc !== 32'h3008 || qi.count !== 2'd1) begin
      fails++; $display("FAIL b2b_head1: got pc=%h cnt=%0d want 3008/1", qi.out_pc, qi.count); end
    tick();
    qi.out_ready = 1'b0;
    tests++; if (qi.out_valid !== 1'b0 || qi.out_ir !== 32'h0 || qi.count !== 2'd0) begin
      fails++; $display("FAIL b2b_drain: got v=%b ir=%h cnt=%0d want 0/0/0", qi.out_valid, qi.out_ir, qi.count); end
  endtask

  task automatic test_wrap();
    qi.out_ready = 1'b1;
    qi.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      qi.in_pc = 32'h4000 + 32'(4 * i);
      qi.in_ir = 32'h00431020;
      tick();
      tests++; if (qi.out_valid !== 1'b1 || qi.out_pc !== 32'h4000 + 32'(4 * i)) begin
        fails++; $display("FAIL wrap_pc%0d: got v=%b pc=%h want %h", i, qi.out_valid, qi.out_pc, 32'h4000 + 32'(4 * i)); end
      tests++; if (qi.count !== 2'd1) begin fails++; $display("FAIL wrap_count%0d: got %0d want 1", i, qi.count); end
    end
    qi.in_valid = 1'b0;
    tick();
    qi.out_ready = 1'b0;
    tests++; if (qi.count !== 2'd0) begin fails++; $display("FAIL wrap_drain: got %0d want 0", qi.count); end
  endtask

  task automatic test_flush();
    qi.out_ready = 1'b0;
    qi.in_valid = 1'b1; qi.in_pc = 32'h3010; qi.in_ir = 32'h00431020;
    tick();
    tests++; if (qi.count !== 2'd1) begin fails++; $display("FAIL flush_pre: got %0d want 1", qi.count); end
    flush = 1'b1; qi.in_pc = 32'h300c;
    tick();
    flush = 1'b0; qi.in_valid = 1'b0;
    tests++; if (qi.count !== 2'd0 || qi.out_valid !== 1'b0) begin
      fails++; $display("FAIL flush_clear: got cnt=%0d v=%b want 0/0", qi.count, qi.out_valid); end
    qi.out_ready = 1'b1;
    tick(); tick();
    tests++; if (qi.out_valid !== 1'b0 || qi.out_pc !== 32'h0) begin
      fails++; $display("FAIL flush_drop: got v=%b pc=%h want 0/0", qi.out_valid, qi.out_pc); end
    qi.out_ready = 1'b0;
  endtask

  task automatic test_md();
    logic [31:0] irs [3];
    logic        exp [3];
    irs[0] = 32'h70430000; exp[0] = MD_ON;
    irs[1] = 32'h00001012; exp[1] = MD_ON;
    irs[2] = 32'h00431020; exp[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      qi.out_ready = 1'b0;
      qi.in_valid = 1'b1; qi.in_pc = 32'h5000 + 32'(4 * i); qi.in_ir = irs[i];
      tick();
      qi.in_valid = 1'b0;
      tests++; if (qi.out_md !== exp[i] || qi.out_ir !== irs[i]) begin
        fails++; $display("FAIL md%0d: got md=%b ir=%h want md=%b ir=%h", i, qi.out_md, qi.out_ir, exp[i], irs[i]); end
      qi.out_ready = 1'b1;
      tick();
    end
    qi.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    qi.out_ready = 1'b0;
    qi.in_valid = 1'b1; qi.in_pc = 32'h6000; qi.in_ir = 32'h00851020;
    tick();
    qi.in_pc = 32'h6004;
    tick();
    qi.in_valid = 1'b0;
    tests++; if (qi.count !== 2'd2) begin fails++; $display("FAIL rmid_pre: got %0d want 2", qi.count); end
    #3 reset = 1'b0;
    #1;
    tests++; if (qi.count !== 2'd0 || qi.out_valid !== 1'b0 || qi.out_ir !== 32'h0) begin
      fails++; $display("FAIL rmid_async: got cnt=%0d v=%b ir=%h want 0/0/0", qi.count, qi.out_valid, qi.out_ir); end
    reset = 1'b1;
    tick();
    tests++; if (qi.in_ready !== 1'b1 || qi.out_valid !== 1'b0) begin
      fails++; $display("FAIL rmid_release: got rdy=%b v=%b want 1/0", qi.in_ready, qi.out_valid); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_md();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised IF/ID boundary that replaces the single-entry fetch/decode register with a small instruction queue using valid/ready handshakes. Fetch pushes (PC, instruction) pairs, and decode pops them in order. A synchronous flush empties the queue on redirects. An optional predecode stage stores a per-entry "uses HI/LO unit" flag so that decode can stall on the multiply/divide unit without re-decoding.

## Interface
Parameters:
- DATA_W, 32: width of the PC and instruction fields.
- DEPTH, 2: number of queue entries. Must be a power of two and at least 2.
- CNT_W, $clog2(DEPTH)+1: width of `count`. This is derived and must not be overridden.

Ports:
- clk, input, 1: single clock. All state changes on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous queue clear.
- in_valid, input, 1: fetch offers an entry.
- in_ready, output, 1: queue accepts the entry this cycle.
- in_pc, input, DATA_W: PC of the offered instruction.
- in_ir, input, DATA_W: offered instruction word.
- out_valid, output, 1: the head entry is valid.
- out_ready, input, 1: decode consumes the head this cycle.
- out_pc, output, DATA_W: PC of the head entry.
- out_ir, output, DATA_W: instruction word of the head entry.
- out_md, output, 1: the head instruction uses the HI/LO unit.
- count, output, CNT_W: number of occupied entries, in the range 0..DEPTH.

## Operation
- Storage is a circular buffer with DEPTH entries, a head pointer (rd_ptr), a tail pointer (wr_ptr) and an occupancy counter.
- Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- push = in_valid && in_ready. pop = out_valid && out_ready.
- in_ready = (count != DEPTH) || out_ready. A full queue therefore accepts a push in the same cycle as a pop.
- out_valid = (count != 0).
- On push, the entry at wr_ptr is written and wr_ptr advances.
- On pop, rd_ptr advances.
- If push and pop occur together, count is unchanged. Otherwise count changes by +1 on push alone and -1 on pop alone.
- Pushing into an empty queue with out_ready high is not bypassed. The entry appears at the output on the next cycle.
- While out_valid=0, out_pc, out_ir and out_md are forced to 0. out_ir=0 is a NOP bubble.
- flush has priority over everything else. In a flush cycle:
  - count and both pointers go to 0;
  - a simultaneous push is dropped;
  - a simultaneous pop has no effect.
- in_ready is still computed normally during a flush cycle. Fetch must treat a push in a flush cycle as discarded.
- When reset is asserted (low), the following clear asynchronously, in any state: all pointers, count, and every stored pc/ir/md field.
- After reset is released, the queue is empty, in_ready=1 and out_valid=0.

## Timing
- Push-to-visible latency is 1 cycle.
- Pop takes effect at the rising edge. The next head entry is visible in the following cycle.
- Throughput is 1 entry per cycle sustained at any occupancy.
- in_ready depends combinationally on out_ready. out_valid and all data outputs depend only on registered state.
- Reset values:
  - in_ready=1;
  - out_valid=0;
  - out_pc=0, out_ir=0, out_md=0;
  - count=0.

## Configuration
- Macro: IF_ID_MD_PREDECODE_EN.
- Defined:
  - The md flag is computed from in_ir at push time and stored per entry.
  - md=1 when op=6'h00 and funct is one of 6'h10 (mfhi), 6'h11 (mthi), 6'h12 (mflo), 6'h13 (mtlo), 6'h18 (mult), 6'h19 (multu), 6'h1a (div) or 6'h1b (divu).
  - md=1 also when op=6'h1c and funct=6'h00 (madd).
  - In all other cases md=0.
- Undefined:
  - No md storage is built.
  - out_md is tied to 0.

## Structure
- Shared package `cpu_pkg`: opcode constants OP_SPECIAL and OP_SPECIAL2, the funct constants listed above, and the instruction field bit ranges (op [31:26], funct [5:0]).
- Sub-module `md_predecode`: purely combinational (in_ir → md). Instantiated only under IF_ID_MD_PREDECODE_EN.

## Test plan
- Reset mid-stream: fill 2 entries, then pull reset low between clock edges → count=0, out_valid=0, out_ir=0 immediately, and in_ready=1 after release.
- Fill to full (DEPTH=2) with out_ready=0, pushing pc 0x3000/ir 0x00851020 then pc 0x3004/ir 0x00430018 → count=2, in_ready=0, out_pc=0x3000, out_md=0. After one pop, out_pc=0x3004 and out_md=1 (macro on) or 0 (macro off).
- Full queue with push and pop in the same cycle, pushing 0x3008 → count stays 2, and the pops deliver 0x3004 then 0x3008 in order.
- Pointer wrap: push and pop 5 entries through DEPTH=2 → out_pc sequence matches the push order exactly, with count ≤ 2 throughout.
- flush together with a push of 0x300c while count=1 → next cycle count=0, out_valid=0, and 0x300c never appears at the output.
- madd (ir 0x70430000) and mflo (ir 0x00001012) pushed with the macro defined → out_md=1 for each. add (0x00431020) → out_md=0.
